// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: opcode encodings and FSM state type shared by the multi-cycle ALU.
package mc_alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mc_alu_mul.sv
// mc_alu_mul: LSB-first shift-add unsigned multiplier, one partial product per cycle.
// A start pulse loads the operands and sets the counter to WIDTH; each following
// cycle adds the shifted multiplicand when the current multiplier bit is set.
// 'product' is the accumulator value after the step taken this cycle, so it
// carries the full 2*WIDTH result in the cycle 'done' is high (last step).
module mc_alu_mul import mc_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Accumulator value after this cycle's step; done flags the final step.
  always_comb begin
    product = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    done    = (cnt_reg == CNT_W'(1));
  end

  // Operand load on start, then one shift-add step per cycle while counting down.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      cnt_reg    <= CNT_W'(WIDTH);
    end else if (cnt_reg != '0) begin
      acc_reg    <= product;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshake on both sides.
// Single-cycle ops (ADD/SUB/AND/OR/SLT/NOR/reserved) register their result at
// acceptance; MUL runs through the mc_alu_mul iterator when MC_ALU_MUL_EN is
// defined, otherwise opcode 110 behaves like the reserved opcode.
module mc_alu import mc_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  state_t state_reg, state_next;

  logic             accept;
  logic             start_mul;
  logic             mul_done;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             add_ovf;

  logic [WIDTH-1:0] op_result;
  logic             op_carry;
  logic             op_overflow;

  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             zero_reg;
  logic             carry_reg;
  logic             overflow_reg;

  assign accept = in_valid && in_ready;

`ifdef MC_ALU_MUL_EN
  logic [2*WIDTH-1:0] mul_product;

  assign start_mul = accept && (ctrl == OP_MUL);

  mc_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (start_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
`endif

  // Shared adder: SUB and SLT use a + ~b + 1, so carry-out 1 means no borrow.
  always_comb begin
    is_sub      = (ctrl == OP_SUB) || (ctrl == OP_SLT);
    b_eff       = is_sub ? ~b : b;
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
    add_ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Single-cycle result and flag selection; reserved (and MUL when disabled) yield zeros.
  always_comb begin
    op_result   = '0;
    op_carry    = 1'b0;
    op_overflow = 1'b0;
    case (ctrl)
      OP_ADD, OP_SUB: begin
        op_result   = sum;
        op_carry    = cout;
        op_overflow = add_ovf;
      end
      OP_AND: op_result = a & b;
      OP_OR:  op_result = a | b;
      OP_NOR: op_result = ~(a | b);
      OP_SLT: begin
        op_result[0] = sum[WIDTH-1] ^ add_ovf;
        op_carry     = cout;
        op_overflow  = add_ovf;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, wait for the consumer in HOLD.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = start_mul ? BUSY : HOLD;
      end
      BUSY: begin
        if (mul_done) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == HOLD);
  end

  // Result and flag registers: loaded at single-cycle acceptance or on the final MUL step.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg    <= '0;
      result_hi_reg <= '0;
      zero_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (accept && !start_mul) begin
      result_reg    <= op_result;
      result_hi_reg <= '0;
      zero_reg      <= (op_result == '0);
      carry_reg     <= op_carry;
      overflow_reg  <= op_overflow;
    end
`ifdef MC_ALU_MUL_EN
    else if ((state_reg == BUSY) && mul_done) begin
      result_reg    <= mul_product[WIDTH-1:0];
      result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
      zero_reg      <= (mul_product == '0);
      carry_reg     <= (mul_product[2*WIDTH-1:WIDTH] != '0);
      overflow_reg  <= 1'b0;
    end
`endif
  end

  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zero      = zero_reg;
  assign carry     = carry_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: scoreboard bench for mc_alu (WIDTH = 32); models MUL according to MC_ALU_MUL_EN.
module tb_mc_alu;
  import mc_alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef MC_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result, result_hi;
  logic [2:0]  ctrl;
  logic        zero, carry, overflow;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .overflow(overflow)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written from the opcode definitions.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    exp_t        e;
    logic [32:0] s;
    logic [63:0] p;
    e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
    case (op)
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[31:0]; e.c = s[32];
        e.v = (x[31] == y[31]) && (s[31] != x[31]);
      end
      OP_SUB, OP_SLT: begin
        s = {1'b0, x} + {1'b0, ~y} + 33'd1;
        e.c = s[32];
        e.v = (x[31] != y[31]) && (s[31] != x[31]);
        if (op == OP_SUB) e.res = s[31:0];
        else              e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_NOR: e.res = ~(x | y);
      OP_MUL: begin
        if (MUL_EN) begin
          p = {32'd0, x} * {32'd0, y};
          e.res = p[31:0]; e.hi = p[63:32];
          e.c = (p[63:32] != 0);
          e.lat = WIDTH + 1;
        end
      end
      default: ;
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    check({name, ".result"},    result,    e.res);
    check({name, ".result_hi"}, result_hi, e.hi);
    check({name, ".zero"},      zero,      e.z);
    check({name, ".carry"},     carry,     e.c);
    check({name, ".overflow"},  overflow,  e.v);
  endtask

  // Drive one request, wait for the result, hold it 'hold' cycles, then release it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int hold, input string name);
    exp_t e;
    int   lat;
    @(negedge clk);
    check({name, ".in_ready_idle"}, in_ready, 1);
    a = x; b = y; ctrl = op; in_valid = 1'b1;
    sb.push_back(model(x, y, op));
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ctrl = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({name, ".in_ready_busy"}, in_ready, 0);
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({name, ".out_valid"}, out_valid, 1);
    check({name, ".latency"}, lat, e.lat);
    check_out(name, e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      ctrl = OP_ADD; a = $urandom; b = $urandom;
      @(negedge clk);
      check({name, ".in_ready_hold"}, in_ready, 0);
      check({name, ".out_valid_hold"}, out_valid, 1);
      check_out({name, ".hold"}, e);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".out_valid_released"}, out_valid, 0);
    check({name, ".in_ready_released"}, in_ready, 1);
    $display("op %s ctrl=%0d a=%h b=%h -> result=%h hi=%h z=%0b c=%0b v=%0b lat=%0d",
             name, op, x, y, e.res, e.hi, e.z, e.c, e.v, lat);
  endtask

  task automatic check_reset_state(input string name);
    check({name, ".in_ready"},  in_ready,  1);
    check({name, ".out_valid"}, out_valid, 0);
    check({name, ".result"},    result,    0);
    check({name, ".result_hi"}, result_hi, 0);
    check({name, ".zero"},      zero,      0);
    check({name, ".carry"},     carry,     0);
    check({name, ".overflow"},  overflow,  0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ctrl = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, "add_ovf");
    run_op(OP_SUB, 32'd5,         32'd5,         0, "sub_eq");
    run_op(OP_SUB, 32'd0,         32'd1,         0, "sub_borrow");
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'd1,         0, "slt_neg");
    run_op(OP_SLT, 32'd1,         32'hFFFF_FFFF, 0, "slt_pos");
    run_op(OP_NOR, 32'd0,         32'd0,         0, "nor_zero");
    run_op(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, "and");
    run_op(OP_OR,  32'hF000_0001, 32'h0000_1000, 0, "or");
    run_op(OP_RSVD, 32'h1234_5678, 32'h9ABC_DEF0, 0, "rsvd");
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 5, "add_hold");
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "mul_max");
    run_op(OP_MUL, 32'd12345,     32'd6789,      0, "mul_small");
    run_op(OP_MUL, 32'd0,         32'hDEAD_BEEF, 0, "mul_zero");

    for (int i = 0; i < 20; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, i % 3, "rand");
    end

    // Abort an operation in flight with reset.
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ctrl = OP_MUL; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check_reset_state("abort");
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(negedge clk);
      check("abort.no_out_valid", out_valid, 0);
    end
    run_op(OP_ADD, 32'd2, 32'd3, 0, "add_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
